slot_allocator: RTL and testbench



---
 rtl/slot_allocator.sv | 206 ++++++++++++++++++++
 tb/tb_slot_allocator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/slot_allocator.sv
// slot_allocator: parking-lot occupancy controller serving entry/exit gates over a req/ack handshake.
// Optional macro ALLOC_ROTATE_EN: free-slot search starts after the last granted slot and wraps.
module slot_allocator #(
    parameter int SLOTS = 8,
    parameter int IDW   = 3,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic [IDW-1:0]   exit_slot,
    output logic             entry_ack,
    output logic             entry_nack,
    output logic [IDW-1:0]   entry_slot,
    output logic             exit_ack,
    output logic             exit_err,
    output logic [SLOTS-1:0] occupancy,
    output logic [CW-1:0]    parked,
    output logic [CW-1:0]    free,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP      = 2'd1,
        WAIT_DROP = 2'd2
    } state_t;

    localparam logic [IDW:0]  SLOTS_EXT = (IDW+1)'(SLOTS);
    localparam logic [CW-1:0] SLOTS_CNT = CW'(SLOTS);

    function automatic logic [CW-1:0] popcount(input logic [SLOTS-1:0] vec);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
        return cnt;
    endfunction

    // First zero bit at or after start, wrapping modulo SLOTS; scanning downwards lets the closest win.
    function automatic logic [IDW-1:0] find_free(input logic [SLOTS-1:0] vec,
                                                 input logic [IDW-1:0]   start);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] cand;
        idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            cand = IDW'((int'(start) + i) % SLOTS);
            if (!vec[cand]) begin
                idx = cand;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t           state_q, state_d;
    logic             serve_exit_q, serve_exit_d;
    logic [IDW-1:0]   exit_slot_q, exit_slot_d;
    logic [SLOTS-1:0] occ_q, occ_d;
    logic [CW-1:0]    parked_q, parked_d;
    logic [CW-1:0]    free_q, free_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [IDW-1:0]   entry_slot_q, entry_slot_d;
    logic             entry_ack_q, entry_ack_d;
    logic             entry_nack_q, entry_nack_d;
    logic             exit_ack_q, exit_ack_d;
    logic             exit_err_q, exit_err_d;

    logic [IDW-1:0]   search_start_s;
    logic [IDW-1:0]   sel_slot_s;
    logic             exit_slot_ok_s;
    logic             served_req_s;

`ifdef ALLOC_ROTATE_EN
    logic [IDW-1:0]   ptr_q, ptr_d;
    assign search_start_s = ptr_q;
`else
    assign search_start_s = '0;
`endif

    assign sel_slot_s     = find_free(occ_q, search_start_s);
    assign exit_slot_ok_s = ({1'b0, exit_slot_q} < SLOTS_EXT);
    assign served_req_s   = serve_exit_q ? exit_req : entry_req;

    // Next-state: request arbitration, one-cycle response and counts derived from the next occupancy.
    always_comb begin
        state_d      = state_q;
        serve_exit_d = serve_exit_q;
        exit_slot_d  = exit_slot_q;
        occ_d        = occ_q;
        entry_slot_d = entry_slot_q;
        entry_ack_d  = 1'b0;
        entry_nack_d = 1'b0;
        exit_ack_d   = 1'b0;
        exit_err_d   = 1'b0;
`ifdef ALLOC_ROTATE_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (exit_req) begin
                    serve_exit_d = 1'b1;
                    exit_slot_d  = exit_slot;
                    state_d      = RESP;
                end else if (entry_req) begin
                    serve_exit_d = 1'b0;
                    state_d      = RESP;
                end else begin
                    state_d      = IDLE;
                end
            end
            RESP: begin
                if (serve_exit_q) begin
                    if (exit_slot_ok_s && occ_q[exit_slot_q]) begin
                        occ_d[exit_slot_q] = 1'b0;
                        exit_ack_d         = 1'b1;
                    end else begin
                        exit_err_d         = 1'b1;
                    end
                end else begin
                    if (full_q) begin
                        entry_nack_d       = 1'b1;
                    end else begin
                        occ_d[sel_slot_s]  = 1'b1;
                        entry_slot_d       = sel_slot_s;
                        entry_ack_d        = 1'b1;
`ifdef ALLOC_ROTATE_EN
                        ptr_d              = IDW'((int'(sel_slot_s) + 1) % SLOTS);
`endif
                    end
                end
                state_d = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!served_req_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        parked_d = popcount(occ_d);
        free_d   = SLOTS_CNT - parked_d;
        full_d   = (parked_d == SLOTS_CNT);
        empty_d  = (parked_d == {CW{1'b0}});
    end

    // State and registered outputs; everything clears the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            serve_exit_q <= 1'b0;
            exit_slot_q  <= '0;
            occ_q        <= '0;
            parked_q     <= '0;
            free_q       <= SLOTS_CNT;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            entry_slot_q <= '0;
            entry_ack_q  <= 1'b0;
            entry_nack_q <= 1'b0;
            exit_ack_q   <= 1'b0;
            exit_err_q   <= 1'b0;
`ifdef ALLOC_ROTATE_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            serve_exit_q <= serve_exit_d;
            exit_slot_q  <= exit_slot_d;
            occ_q        <= occ_d;
            parked_q     <= parked_d;
            free_q       <= free_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            entry_slot_q <= entry_slot_d;
            entry_ack_q  <= entry_ack_d;
            entry_nack_q <= entry_nack_d;
            exit_ack_q   <= exit_ack_d;
            exit_err_q   <= exit_err_d;
`ifdef ALLOC_ROTATE_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign occupancy  = occ_q;
    assign parked     = parked_q;
    assign free       = free_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign entry_slot = entry_slot_q;
    assign entry_ack  = entry_ack_q;
    assign entry_nack = entry_nack_q;
    assign exit_ack   = exit_ack_q;
    assign exit_err   = exit_err_q;

endmodule

// File: tb/tb_slot_allocator.sv
// Randomized bench for slot_allocator: transaction-level lot model predicts every output each cycle.
module tb_slot_allocator;
    localparam int SLOTS = 8;
    localparam int IDW   = 3;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             entry_req = 1'b0;
    logic             exit_req = 1'b0;
    logic [IDW-1:0]   exit_slot = '0;
    logic             entry_ack, entry_nack, exit_ack, exit_err;
    logic [IDW-1:0]   entry_slot;
    logic [SLOTS-1:0] occupancy;
    logic [CW-1:0]    parked, free;
    logic             full, empty;

    slot_allocator #(.SLOTS(SLOTS), .IDW(IDW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
        .exit_slot(exit_slot), .entry_ack(entry_ack), .entry_nack(entry_nack),
        .entry_slot(entry_slot), .exit_ack(exit_ack), .exit_err(exit_err),
        .occupancy(occupancy), .parked(parked), .free(free), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference lot: one flag per slot, last granted index, expected pulse {eack,enack,xack,xerr}.
    bit       m_occ [SLOTS];
    int       m_slot = 0;
    int       m_ptr  = 0;
    bit [3:0] m_pulse = 4'b0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < SLOTS; i++) c += int'(m_occ[i]);
        return c;
    endfunction

    function automatic logic [SLOTS-1:0] m_vec();
        logic [SLOTS-1:0] v = '0;
        for (int i = 0; i < SLOTS; i++) v[i] = m_occ[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < SLOTS; i++) m_occ[i] = 1'b0;
        m_slot = 0; m_ptr = 0; m_pulse = 4'b0000;
    endtask

    task automatic m_apply(input bit is_exit, input int slot);
        int s;
        if (is_exit) begin
            if (slot < SLOTS && m_occ[slot]) begin
                m_occ[slot] = 1'b0; m_pulse = 4'b0010;
            end else m_pulse = 4'b0001;
        end else if (m_count() == SLOTS) begin
            m_pulse = 4'b0100;
        end else begin
            s = -1;
            for (int k = 0; k < SLOTS; k++) begin
`ifdef ALLOC_ROTATE_EN
                if (s < 0 && !m_occ[(m_ptr + k) % SLOTS]) s = (m_ptr + k) % SLOTS;
`else
                if (s < 0 && !m_occ[k]) s = k;
`endif
            end
            m_occ[s] = 1'b1; m_slot = s; m_ptr = (s + 1) % SLOTS; m_pulse = 4'b1000;
        end
    endtask

    // Every falling edge: all outputs against the reference lot.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("occupancy",  32'(occupancy),  32'(m_vec()));
            chk("parked",     32'(parked),     32'(m_count()));
            chk("free",       32'(free),       32'(SLOTS - m_count()));
            chk("full",       32'(full),       32'(m_count() == SLOTS));
            chk("empty",      32'(empty),      32'(m_count() == 0));
            chk("entry_slot", 32'(entry_slot), 32'(m_slot));
            chk("pulses",     32'({entry_ack, entry_nack, exit_ack, exit_err}), 32'(m_pulse));
        end
    end

    // One served request: sampled at the next edge, answered after the following one, then dropped.
    task automatic serve(input bit is_exit, input int slot, output logic [3:0] seen);
        @(posedge clk);
        @(posedge clk); #1;
        m_apply(is_exit, slot);
        @(negedge clk);
        seen = {entry_ack, entry_nack, exit_ack, exit_err};
        if (is_exit) exit_req = 1'b0; else entry_req = 1'b0;
        @(posedge clk); #1;
        m_pulse = 4'b0000;
        @(negedge clk);
    endtask

    task automatic do_entry(output logic [3:0] seen);
        entry_req = 1'b1;
        serve(1'b0, 0, seen);
    endtask

    task automatic do_exit(input int slot, output logic [3:0] seen);
        exit_req = 1'b1; exit_slot = IDW'(slot);
        serve(1'b1, slot, seen);
    endtask

    task automatic hard_reset();
        #1 rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] s1, s2;
        int kind, slot;
        m_reset();
        hard_reset();
        chk_en = 1'b1;
        chk("reset occupancy", 32'(occupancy), 32'h0);
        chk("reset free", 32'(free), 32'd8);
        chk("reset empty", 32'(empty), 32'd1);

        for (int i = 0; i < 3; i++) begin
            do_entry(s1);
            chk("first entries ack", 32'(s1), 32'b1000);
            chk("first entries slot", 32'(entry_slot), 32'(i));
        end
        chk("three parked occ", 32'(occupancy), 32'h07);
        chk("three parked cnt", 32'(parked), 32'd3);
        chk("three parked free", 32'(free), 32'd5);

        do_exit(3, s1);
        chk("exit empty slot err", 32'(s1), 32'b0001);
        chk("exit err occ", 32'(occupancy), 32'h07);
        chk("exit err parked", 32'(parked), 32'd3);

        do_exit(1, s1);
        do_exit(2, s1);
        chk("down to one", 32'(occupancy), 32'h01);
        entry_req = 1'b1; exit_req = 1'b1; exit_slot = '0;
        serve(1'b1, 0, s1);
        serve(1'b0, 0, s2);
        chk("both: exit first", 32'(s1), 32'b0010);
        chk("both: entry next", 32'(s2), 32'b1000);
`ifndef ALLOC_ROTATE_EN
        chk("both: slot", 32'(entry_slot), 32'd0);
`endif

        while (m_count() < SLOTS) do_entry(s1);
        chk("fill occ", 32'(occupancy), 32'hFF);
        chk("fill full", 32'(full), 32'd1);
        do_entry(s1);
        chk("full nack only", 32'(s1), 32'b0100);
        chk("full nack occ", 32'(occupancy), 32'hFF);
        do_exit(5, s1);
        chk("exit 5 ack", 32'(s1), 32'b0010);
        chk("exit 5 occ", 32'(occupancy), 32'hDF);
        do_entry(s1);
`ifndef ALLOC_ROTATE_EN
        chk("refill slot 5", 32'(entry_slot), 32'd5);
`endif

        for (int t = 0; t < 200; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            kind = $urandom_range(0, 9);
            slot = $urandom_range(0, SLOTS - 1);
            if (kind < 5) do_entry(s1);
            else if (kind < 9) do_exit(slot, s1);
            else begin
                entry_req = 1'b1; exit_req = 1'b1; exit_slot = IDW'(slot);
                serve(1'b1, slot, s1);
                serve(1'b0, 0, s2);
            end
        end

        hard_reset();
        for (int i = 0; i < 4; i++) do_entry(s1);
        chk("pre-reset occ", 32'(occupancy), 32'h0F);
        entry_req = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("async reset occ", 32'(occupancy), 32'h0);
        chk("async reset parked", 32'(parked), 32'd0);
        chk("async reset free", 32'(free), 32'd8);
        chk("async reset full/empty", 32'({full, empty}), 32'b01);
        chk("async reset slot", 32'(entry_slot), 32'd0);
        chk("async reset pulses", 32'({entry_ack, entry_nack, exit_ack, exit_err}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        serve(1'b0, 0, s1);
        chk("post-reset entry", 32'(s1), 32'b1000);
        chk("post-reset slot", 32'(entry_slot), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
